aipp_release_gate: RTL and testbench
====================================

# aipp_release_gate

Packet hold-and-release stage that sits directly downstream of the MAC/parser and alongside the AIPP lead-time trigger. It buffers ingress packet words in a FIFO and announces each new packet to the trigger with a one-cycle `pkt_detect` pulse. It then holds the packet until the trigger's `data_release` rises, and streams exactly that one packet to egress. It also measures the hold time of every released packet.

## Interface
- `DATA_W`, 64: ingress/egress data width.
- `DEPTH`, 64: FIFO depth in words; power of two, at least 4.
- `HOLD_W`, 32: width of the hold-time counter.

- `clk`  in  1: core clock, 1 GHz.
- `rst_n`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: ingress word valid.
- `in_ready`  out  1: ingress ready; equals `!full`.
- `in_data`  in  `DATA_W`: ingress word.
- `in_last`  in  1: last word of the packet.
- `pkt_detect`  out  1: registered one-cycle pulse to the trigger's `packet_detect`.
- `release_in`  in  1: trigger's `data_release` level; only its rising edge is used.
- `out_valid`  out  1: egress word valid.
- `out_ready`  in  1: egress ready.
- `out_data`  out  `DATA_W`: egress word.
- `out_last`  out  1: last word of the packet.
- `last_hold`  out  `HOLD_W`: cycles spent in ARMED by the most recently released packet.
- `err_spurious`  out  1: sticky flag; a release edge arrived outside ARMED.

## Operation
- FIFO storage:
  - Each word is stored with its `last` bit, so each entry is `DATA_W+1` bits.
  - Write on `in_valid && in_ready`.
  - Read is first-word-fall-through.
  - Occupancy counter is `$clog2(DEPTH)+1` bits; push and pop in the same cycle leave it unchanged.
  - `in_ready` ignores a same-cycle pop, so a full FIFO never accepts a word.
- Edge detect: `release_q` is `release_in` delayed by one cycle; `rel_edge = release_in && !release_q`.
- FSM, 3 states:
  - IDLE: when the FIFO is non-empty, go to ARMED, pulse `pkt_detect`, clear the hold counter. The FIFO head is always a start-of-packet word.
  - ARMED: the hold counter increments every cycle and saturates at all-ones. On `rel_edge`, go to DRAIN and latch the counter value into `last_hold`.
  - DRAIN: `out_valid = !empty`; pop on `out_valid && out_ready`. After popping a word with `last` set, go to IDLE.
- Only one packet is outstanding at a time, so `pkt_detect` never reaches the trigger while it is active.
- Ingress keeps filling the FIFO in every state. A packet longer than `DEPTH` is stalled by backpressure until it is drained.
- A `rel_edge` in IDLE or DRAIN is ignored for state purposes and sets `err_spurious`. Only reset clears it.
- `out_valid` is 0 outside DRAIN. `out_data` and `out_last` are the FIFO head, don't-care when `out_valid` is 0.

## Timing
- Reset values:
  - `in_ready` = 1 (the FIFO is empty).
  - `pkt_detect` = 0, `out_valid` = 0, `out_last` = 0, `out_data` = 0.
  - `last_hold` = 0, `err_spurious` = 0, `release_q` = 0.
  - State = IDLE, FIFO empty.
- Reset mid-operation discards all FIFO contents and the pending packet.
- Ingress to detect: a word written at edge E0 is seen by IDLE as non-empty. `pkt_detect` is high from E1 to E2, i.e. a latency of 1 cycle after the accepting edge.
- Release to egress:
  - `release_in` is first sampled high at edge Er, where `release_q` is still 0; the FSM enters DRAIN at Er.
  - `out_valid` is high in the cycle after Er, so the first word can transfer at Er+1.
- `last_hold` counts every cycle spent in ARMED, from entry through the cycle where the release edge is sampled, inclusive.
- Egress runs at full throughput: one word per cycle while `out_ready` is high and the FIFO is non-empty.
- After `out_last` transfers, IDLE is entered at that edge. If the FIFO is non-empty, the next `pkt_detect` comes one cycle later, giving a minimum gap of 1 cycle between packets.
- A held-high `release_in` produces only one edge. It must fall and rise again before it can release the next packet.

## Structure
- Package `aipp_pkg` holds:
  - the state enum `gate_state_t` (IDLE, ARMED, DRAIN);
  - the FIFO entry struct `{last, data}`;
  - the default parameter constants.
- Sub-module `aipp_sync_fifo`:
  - parameterised by width and depth;
  - single clock, FWFT;
  - ports: `full`, `empty`, `count`.
- The FSM, edge detect and hold counter live in the top module.

## Test plan
- Reset: apply reset, then check `in_ready`=1 and `out_valid`=0. Send a 4-word packet → `pkt_detect` is high for exactly 1 cycle, 1 cycle after the first accept, and `out_valid` stays 0.
- Hold and release: assert `release_in` 14000 cycles after `pkt_detect`. Check that:
  - all 4 words are output in order, with `out_last` on word 4;
  - `last_hold` = 14000 ± 1 per the counting rule above.
- Back-to-back packets: send packets of 3, 1 and 5 words, with release pulses spaced 100 cycles apart. Check 3 `pkt_detect` pulses, each issued only after the previous packet drains.
- Full FIFO: send an 80-word packet with `DEPTH`=64. Check that `in_ready` drops after word 64, the remaining words transfer during DRAIN, and no word is lost or duplicated.
- Spurious release and held release: a release edge in IDLE sets `err_spurious`. `release_in` held high across two packets releases only the first packet.
- Mid-drain reset and egress stalls:
  - Assert reset halfway through DRAIN → all outputs take their reset values and the FIFO is empty.
  - Toggle `out_ready` randomly → the data order is preserved.

Source files
------------

// File: rtl/aipp_pkg.sv
// Shared types and default sizing for the AIPP packet hold-and-release gate.
package aipp_pkg;

  localparam int AIPP_DATA_W = 64;
  localparam int AIPP_DEPTH  = 64;
  localparam int AIPP_HOLD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARMED,
    ST_DRAIN
  } gate_state_t;

  typedef struct packed {
    logic                   last;
    logic [AIPP_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/aipp_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count.
module aipp_sync_fifo
  import aipp_pkg::*;
#(
  parameter  int WIDTH = AIPP_DATA_W + 1,
  parameter  int DEPTH = AIPP_DEPTH,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             push, pop;

  assign full  = (count_q == (AW+1)'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign push  = wr_en && !full;
  assign pop   = rd_en && !empty;

  // Head reads as zero when empty so the egress bus is clean out of reset.
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/aipp_release_gate.sv
// Holds each buffered packet until the trigger releases it, then streams it out
// and records how long it was held.
//   state    | meaning
//   ST_IDLE  | waiting for a packet head in the FIFO
//   ST_ARMED | packet announced, hold counter running, waiting for release edge
//   ST_DRAIN | streaming the held packet until its last word leaves
module aipp_release_gate
  import aipp_pkg::*;
#(
  parameter int DATA_W = AIPP_DATA_W,
  parameter int DEPTH  = AIPP_DEPTH,
  parameter int HOLD_W = AIPP_HOLD_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              pkt_detect,
  input  logic              release_in,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic [HOLD_W-1:0] last_hold,
  output logic              err_spurious
);

  localparam int AW = $clog2(DEPTH);

  gate_state_t       state_q, state_d;
  logic [HOLD_W-1:0] hold_q, hold_d, hold_inc;
  logic [HOLD_W-1:0] last_hold_q, last_hold_d;
  logic              pkt_detect_q, pkt_detect_d;
  logic              err_q, err_d;
  logic              release_q;
  logic              rel_edge;
  logic              pop;

  logic [DATA_W:0]   fifo_rd_data;
  logic              fifo_full, fifo_empty;
  logic [AW:0]       fifo_count;

  aipp_sync_fifo #(
    .WIDTH (DATA_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (in_valid && in_ready),
    .wr_data ({in_last, in_data}),
    .rd_en   (pop),
    .rd_data (fifo_rd_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign in_ready               = !fifo_full;
  assign {out_last, out_data}   = fifo_rd_data;
  assign out_valid              = (state_q == ST_DRAIN) && !fifo_empty;
  assign pop                    = out_valid && out_ready;
  assign rel_edge               = release_in && !release_q;
  assign hold_inc               = (&hold_q) ? hold_q : hold_q + HOLD_W'(1);
  assign pkt_detect             = pkt_detect_q;
  assign last_hold              = last_hold_q;
  assign err_spurious           = err_q;

  always_comb begin
    state_d      = state_q;
    hold_d       = hold_q;
    last_hold_d  = last_hold_q;
    pkt_detect_d = 1'b0;
    err_d        = err_q;
    case (state_q)
      ST_IDLE: begin
        if (fifo_count != '0) begin
          state_d      = ST_ARMED;
          pkt_detect_d = 1'b1;
          hold_d       = '0;
        end
      end
      ST_ARMED: begin
        hold_d = hold_inc;
        // Latched value includes the cycle in which the edge is sampled.
        if (rel_edge) begin
          state_d     = ST_DRAIN;
          last_hold_d = hold_inc;
        end
      end
      ST_DRAIN: begin
        if (pop && out_last) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (rel_edge && (state_q != ST_ARMED)) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      hold_q       <= '0;
      last_hold_q  <= '0;
      pkt_detect_q <= 1'b0;
      err_q        <= 1'b0;
      release_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_q       <= hold_d;
      last_hold_q  <= last_hold_d;
      pkt_detect_q <= pkt_detect_d;
      err_q        <= err_d;
      release_q    <= release_in;
    end
  end

endmodule

// File: tb/tb_aipp_release_gate.sv
// Directed bench for the release gate: detect timing, hold measurement, back-to-back,
// full FIFO, spurious/held release, mid-drain reset and egress stalls.
module tb_aipp_release_gate;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic        in_last;
  logic        pkt_detect;
  logic        release_in;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic [31:0] last_hold;
  logic        err_spurious;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int det_cnt = 0;
  int det_cyc = 0;
  int acc_cyc = 0;
  int last_cyc = 0;
  int nacc = 0;
  int stall_at = -1;
  int det0;
  int tw;

  localparam logic [63:0] B0 = 64'hA000_0000_0000_0000;
  localparam logic [63:0] B1 = 64'hB100_0000_0000_0000;
  localparam logic [63:0] B2 = 64'hB200_0000_0000_0000;
  localparam logic [63:0] B3 = 64'hB300_0000_0000_0000;
  localparam logic [63:0] B4 = 64'hC400_0000_0000_0000;
  localparam logic [63:0] B5 = 64'hD500_0000_0000_0000;
  localparam logic [63:0] B6 = 64'hD600_0000_0000_0000;
  localparam logic [63:0] B7 = 64'hE700_0000_0000_0000;
  localparam logic [63:0] B8 = 64'hF800_0000_0000_0000;

  aipp_release_gate dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_last      (in_last),
    .pkt_detect   (pkt_detect),
    .release_in   (release_in),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .last_hold    (last_hold),
    .err_spurious (err_spurious)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (pkt_detect === 1'b1) begin
    det_cnt++;
    det_cyc = cyc;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_pkt(input int n, input logic [63:0] base);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = base + 64'(i);
      in_last  = (i == n - 1);
      while (!in_ready && t < 3000) begin
        if (stall_at < 0) stall_at = nacc;
        @(negedge clk);
        t++;
      end
      if (t >= 3000) begin
        checks++;
        errors++;
        $error("FAIL ingress_timeout observed=%0d expected=<3000", t);
      end
      @(posedge clk);
      #1;
      if (i == 0) acc_cyc = cyc;
      nacc++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(input int n, input logic [63:0] base, input bit rnd, input int total);
    int got = 0;
    int t = 0;
    while (got < n && t < 3000) begin
      @(negedge clk);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (out_valid && out_ready) begin
        chk("egress_data", out_data, base + 64'(got));
        chk("egress_last", 64'(out_last), 64'(got == total - 1));
        got++;
        @(posedge clk);
        #1;
        last_cyc = cyc;
      end
      t++;
    end
    out_ready = 1'b0;
    chk("egress_count", 64'(got), 64'(n));
  endtask

  task automatic pulse_release();
    @(negedge clk);
    release_in = 1'b1;
    repeat (2) @(negedge clk);
    release_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    release_in = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_pkt_detect", 64'(pkt_detect), 64'd0);
    chk("rst_out_data", out_data, 64'd0);
    chk("rst_last_hold", 64'(last_hold), 64'd0);
    chk("rst_err", 64'(err_spurious), 64'd0);

    // 4-word packet: one detect pulse, one cycle after the first accept, held
    send_pkt(4, B0);
    repeat (5) @(negedge clk);
    chk("detect_count", 64'(det_cnt), 64'd1);
    chk("detect_latency", 64'(det_cyc), 64'(acc_cyc + 1));
    chk("held_out_valid", 64'(out_valid), 64'd0);

    // release set just after edge det+14000, sampled at det+14001: 14001 ARMED cycles
    while (cyc < det_cyc + 14000) @(negedge clk);
    release_in = 1'b1;
    collect(4, B0, 1'b0, 4);
    release_in = 1'b0;
    chk("last_hold", 64'(last_hold), 64'd14001);
    chk("err_after_release", 64'(err_spurious), 64'd0);

    // back-to-back 3, 1, 5
    det0 = det_cnt;
    send_pkt(3, B1);
    send_pkt(1, B2);
    send_pkt(5, B3);
    repeat (3) @(negedge clk);
    chk("b2b_single_detect", 64'(det_cnt), 64'(det0 + 1));
    pulse_release();
    collect(3, B1, 1'b0, 3);
    repeat (3) @(negedge clk);
    chk("b2b_detect2", 64'(det_cnt), 64'(det0 + 2));
    chk("b2b_gap2", 64'(det_cyc), 64'(last_cyc + 1));
    repeat (100) @(negedge clk);
    pulse_release();
    collect(1, B2, 1'b0, 1);
    repeat (3) @(negedge clk);
    chk("b2b_detect3", 64'(det_cnt), 64'(det0 + 3));
    chk("b2b_gap3", 64'(det_cyc), 64'(last_cyc + 1));
    repeat (100) @(negedge clk);
    pulse_release();
    collect(5, B3, 1'b0, 5);
    repeat (5) @(negedge clk);
    chk("b2b_no_extra_detect", 64'(det_cnt), 64'(det0 + 3));
    chk("b2b_idle_out_valid", 64'(out_valid), 64'd0);

    // 80-word packet through a 64-deep FIFO
    nacc = 0;
    stall_at = -1;
    fork
      send_pkt(80, B4);
      begin
        tw = 0;
        while (nacc < 64 && tw < 500) begin
          @(negedge clk);
          tw++;
        end
        repeat (2) @(negedge clk);
        chk("full_in_ready", 64'(in_ready), 64'd0);
        chk("full_accepted", 64'(nacc), 64'd64);
        pulse_release();
        collect(80, B4, 1'b0, 80);
      end
    join
    chk("full_stall_point", 64'(stall_at), 64'd64);
    chk("full_total_accepted", 64'(nacc), 64'd80);

    // spurious edge in IDLE, then a level held high across two packets
    repeat (3) @(negedge clk);
    chk("err_before_spurious", 64'(err_spurious), 64'd0);
    pulse_release();
    repeat (2) @(negedge clk);
    chk("err_spurious_set", 64'(err_spurious), 64'd1);
    chk("spurious_no_drain", 64'(out_valid), 64'd0);
    send_pkt(2, B5);
    repeat (3) @(negedge clk);
    release_in = 1'b1;
    collect(2, B5, 1'b0, 2);
    det0 = det_cnt;
    send_pkt(2, B6);
    repeat (50) @(negedge clk);
    chk("held_detect", 64'(det_cnt), 64'(det0 + 1));
    chk("held_no_release", 64'(out_valid), 64'd0);
    release_in = 1'b0;
    repeat (2) @(negedge clk);
    release_in = 1'b1;
    collect(2, B6, 1'b0, 2);
    release_in = 1'b0;
    chk("err_still_set", 64'(err_spurious), 64'd1);

    // reset halfway through an 8-word drain
    send_pkt(8, B7);
    pulse_release();
    collect(4, B7, 1'b0, 8);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_in_ready", 64'(in_ready), 64'd1);
    chk("mid_rst_out_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_pkt_detect", 64'(pkt_detect), 64'd0);
    chk("mid_rst_out_last", 64'(out_last), 64'd0);
    chk("mid_rst_out_data", out_data, 64'd0);
    chk("mid_rst_last_hold", 64'(last_hold), 64'd0);
    chk("mid_rst_err", 64'(err_spurious), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    det0 = det_cnt;
    repeat (5) @(negedge clk);
    chk("post_rst_no_detect", 64'(det_cnt), 64'(det0));
    chk("post_rst_out_valid", 64'(out_valid), 64'd0);

    // random egress stalls keep order
    send_pkt(12, B8);
    repeat (2) @(negedge clk);
    chk("stall_detect", 64'(det_cnt), 64'(det0 + 1));
    pulse_release();
    collect(12, B8, 1'b1, 12);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
